decode_stage: RTL and testbench

Parametrised instruction-decode stage sitting between the IF/ID and ID/EX pipeline registers of the SoC datapath. It performs several jobs:
- Field extraction and register-file read requests.
- Operand-forwarding selection and load-use hazard detection.
- Early branch resolution.
- Return-instruction stall sequencing.

It owns the ID/EX register, inserting bubbles itself, so the hazard unit only arbitrates `request_stall` against other stages.

---
 rtl/decode_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Instruction-decode stage between the IF/ID and ID/EX pipeline registers.
// It extracts instruction fields and drives register-file read requests. It
// selects operand forwarding and detects load-use hazards, resolves BEQ early
// (optional), and sequences the fetch stall that follows a return. The stage
// owns the ID/EX register and inserts bubbles itself, so the hazard unit only
// has to arbitrate request_stall against the other stages.
//
// Instruction layout (32 bits):
//   [31:24]            opcode
//   [23 -: ADDR_W]     rd
//   next ADDR_W bits   rs1
//   next ADDR_W bits   rs2
//   [IMM_W-1:0]        imm, IMM_W = 24 - 3*ADDR_W
//
// Opcode classes (opcode[7:6]):
//   00 ALU reg-reg (rs1, rs2 -> rd)    01 ALU imm (rs1 -> rd)
//   10 memory: opcode[5]=0 load (rs1 -> rd), 1 store (rs1, rs2)
//   11 control: opcode[5:4] 00 BEQ (rs1, rs2), 01 call, 10 ret, 11 nop
//
// Optional feature macro: DECODE_BRANCH_RESOLVE_EN
//   defined   : BEQ compared in ID on forwarded operands; a taken branch
//               redirects fetch and loads a bubble. BEQ also stalls while
//               its source is still being produced by the EX instruction.
//   undefined : take_branch_address/branch_offset tied 0, BEQ flows to EX
//               as an ordinary instruction, only load-use stalls remain.
//
// Ports:
//   clock, nreset                 clock; asynchronous active-low reset
//   stall                         global stall, freezes ID/EX and the FSM
//   instruction_word, instr_valid IF/ID contents
//   reg_file_ren[1:0]             read enables {rs2, rs1}        (comb)
//   reg_file_read_addr            read addresses {rs2, rs1}      (comb)
//   rs1_data, rs2_data            register-file read data
//   ex_mem_rd/wen/result          EX/MEM destination for forwarding
//   mem_wb_rd/wen/result          MEM/WB destination for forwarding
//   take_branch_address           BEQ taken, redirect fetch      (comb)
//   branch_offset                 raw imm of the BEQ             (comb)
//   request_stall                 stall request to hazard unit   (comb)
//   ret                           one-cycle return-accepted pulse (reg)
//   ex_valid, ex_opcode, ex_rd, ex_imm, ex_wen, ex_fwd_a, ex_fwd_b
//                                 ID/EX register contents         (reg)
//   Forward select encoding: 00 register file, 01 EX/MEM, 10 MEM/WB.
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter  int ADDR_W  = 5,
    parameter  int DATA_W  = 32,
    parameter  int RET_LAT = 2,
    localparam int IMM_W   = 24 - 3 * ADDR_W
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  stall,
    input  logic [31:0]           instruction_word,
    input  logic                  instr_valid,
    output logic [1:0]            reg_file_ren,
    output logic [2*ADDR_W-1:0]   reg_file_read_addr,
    input  logic [DATA_W-1:0]     rs1_data,
    input  logic [DATA_W-1:0]     rs2_data,
    input  logic [ADDR_W-1:0]     ex_mem_rd,
    input  logic [ADDR_W-1:0]     mem_wb_rd,
    input  logic                  ex_mem_wen,
    input  logic                  mem_wb_wen,
    input  logic [DATA_W-1:0]     ex_mem_result,
    input  logic [DATA_W-1:0]     mem_wb_result,
    output logic                  take_branch_address,
    output logic [IMM_W-1:0]      branch_offset,
    output logic                  request_stall,
    output logic                  ret,
    output logic                  ex_valid,
    output logic [7:0]            ex_opcode,
    output logic [ADDR_W-1:0]     ex_rd,
    output logic [IMM_W-1:0]      ex_imm,
    output logic                  ex_wen,
    output logic [1:0]            ex_fwd_a,
    output logic [1:0]            ex_fwd_b
);

    localparam int                CNT_W     = $clog2(RET_LAT + 1);
    localparam logic [CNT_W-1:0]  RET_LAT_C = CNT_W'(RET_LAT);
    localparam logic [1:0]        FWD_RF    = 2'b00;
    localparam logic [1:0]        FWD_EXMEM = 2'b01;
    localparam logic [1:0]        FWD_MEMWB = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_RET_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ret;
    logic                r_ex_valid;
    logic [7:0]          r_ex_opcode;
    logic [ADDR_W-1:0]   r_ex_rd;
    logic [IMM_W-1:0]    r_ex_imm;
    logic                r_ex_wen;
    logic [1:0]          r_ex_fwd_a;
    logic [1:0]          r_ex_fwd_b;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [7:0]          w_opcode;
    logic [ADDR_W-1:0]   w_rd;
    logic [ADDR_W-1:0]   w_rs1;
    logic [ADDR_W-1:0]   w_rs2;
    logic [IMM_W-1:0]    w_imm;

    assign w_opcode = instruction_word[31:24];
    assign w_rd     = instruction_word[23 -: ADDR_W];
    assign w_rs1    = instruction_word[23 - ADDR_W -: ADDR_W];
    assign w_rs2    = instruction_word[23 - 2 * ADDR_W -: ADDR_W];
    assign w_imm    = instruction_word[IMM_W-1:0];

    // ------------------------------------------------------------------
    // Class decode
    // ------------------------------------------------------------------
    logic w_use_rs1;
    logic w_use_rs2;
    logic w_writes_rd;
    logic w_is_beq;
    logic w_is_ret;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave one unassigned and infer a latch.
    always_comb begin
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_writes_rd = 1'b0;
        w_is_beq    = 1'b0;
        w_is_ret    = 1'b0;
        unique case (w_opcode[7:6])
            2'b00: begin
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_writes_rd = 1'b1;
            end
            2'b01: begin
                w_use_rs1   = 1'b1;
                w_writes_rd = 1'b1;
            end
            2'b10: begin
                w_use_rs1 = 1'b1;
                if (w_opcode[5]) begin
                    w_use_rs2 = 1'b1;       // store: address base + data
                end else begin
                    w_writes_rd = 1'b1;     // load
                end
            end
            2'b11: begin
                case (w_opcode[5:4])
                    2'b00: begin
                        w_is_beq  = 1'b1;
                        w_use_rs1 = 1'b1;
                        w_use_rs2 = 1'b1;
                    end
                    2'b10:   w_is_ret = 1'b1;
                    default: ;              // call, nop: no sources, no write
                endcase
            end
        endcase
    end

    // While waiting out a return, IF/ID content is ignored entirely.
    logic w_id_valid;
    logic w_rd_rs1;
    logic w_rd_rs2;

    assign w_id_valid = nreset & instr_valid & (r_state == S_IDLE);
    assign w_rd_rs1   = w_id_valid & w_use_rs1;
    assign w_rd_rs2   = w_id_valid & w_use_rs2;

    assign reg_file_ren       = {w_rd_rs2, w_rd_rs1};
    assign reg_file_read_addr = nreset ? {w_rs2, w_rs1} : '0;

    // ------------------------------------------------------------------
    // Forwarding select: EX/MEM beats MEM/WB, register 0 never forwards
    // ------------------------------------------------------------------
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    always_comb begin
        w_fwd_a = FWD_RF;
        if (w_rd_rs1 && (w_rs1 != '0)) begin
            if (ex_mem_wen && (ex_mem_rd == w_rs1)) begin
                w_fwd_a = FWD_EXMEM;
            end else if (mem_wb_wen && (mem_wb_rd == w_rs1)) begin
                w_fwd_a = FWD_MEMWB;
            end
        end
    end

    always_comb begin
        w_fwd_b = FWD_RF;
        if (w_rd_rs2 && (w_rs2 != '0)) begin
            if (ex_mem_wen && (ex_mem_rd == w_rs2)) begin
                w_fwd_b = FWD_EXMEM;
            end else if (mem_wb_wen && (mem_wb_rd == w_rs2)) begin
                w_fwd_b = FWD_MEMWB;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dependencies on the instruction currently in ID/EX
    // ------------------------------------------------------------------
    logic w_ex_hit;
    logic w_ex_is_load;
    logic w_load_use;

    assign w_ex_hit     = (w_rd_rs1 && (r_ex_rd == w_rs1)) ||
                          (w_rd_rs2 && (r_ex_rd == w_rs2));
    assign w_ex_is_load = r_ex_valid && (r_ex_opcode[7:6] == 2'b10) && !r_ex_opcode[5];
    assign w_load_use   = w_ex_is_load && (r_ex_rd != '0) && w_ex_hit;

    // ------------------------------------------------------------------
    // Early branch resolution
    // ------------------------------------------------------------------
    logic              w_beq_dep;
    logic              w_taken;
    logic [IMM_W-1:0]  w_branch_offset;

`ifdef DECODE_BRANCH_RESOLVE_EN
    logic              w_beq;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;

    assign w_beq = w_id_valid && w_is_beq;

    // Any in-flight producer in EX has no result to forward yet, so BEQ must
    // wait a cycle even for ALU results that plain instructions could bypass.
    assign w_beq_dep = w_beq && r_ex_valid && r_ex_wen && w_ex_hit;

    assign w_op_a = (w_fwd_a == FWD_EXMEM) ? ex_mem_result :
                    (w_fwd_a == FWD_MEMWB) ? mem_wb_result : rs1_data;
    assign w_op_b = (w_fwd_b == FWD_EXMEM) ? ex_mem_result :
                    (w_fwd_b == FWD_MEMWB) ? mem_wb_result : rs2_data;

    assign w_taken         = w_beq && !w_beq_dep && !w_load_use && (w_op_a == w_op_b);
    assign w_branch_offset = w_beq ? w_imm : '0;
`else
    // Compare operands are only needed when branches resolve here.
    logic w_unused_branch_data;
    assign w_unused_branch_data = ^{rs1_data, rs2_data, ex_mem_result,
                                    mem_wb_result, w_is_beq};

    assign w_beq_dep       = 1'b0;
    assign w_taken         = 1'b0;
    assign w_branch_offset = '0;
`endif

    assign take_branch_address = w_taken;
    assign branch_offset       = w_branch_offset;

    // ------------------------------------------------------------------
    // Stall request and bubble decision
    // ------------------------------------------------------------------
    logic w_req_stall;
    logic w_bubble;
    logic w_ret_accept;

    assign w_req_stall  = nreset && (w_load_use || w_beq_dep || (r_state == S_RET_WAIT));
    assign request_stall = w_req_stall;

    // A taken branch squashes the BEQ itself; fetch flushes what follows.
    assign w_bubble     = !w_id_valid || w_req_stall || w_taken;
    assign w_ret_accept = w_id_valid && w_is_ret && !stall && !w_req_stall;

    // ------------------------------------------------------------------
    // Return sequencing FSM
    // ------------------------------------------------------------------
    state_t            w_next_state;
    logic [CNT_W-1:0]  w_next_cnt;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (!stall) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_ret_accept) begin
                        w_next_state = S_RET_WAIT;
                        w_next_cnt   = RET_LAT_C;
                    end
                end
                S_RET_WAIT: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        w_next_state = S_IDLE;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    // NOTE: this is a handful of control flops, not a memory array, so every
    // bit takes the asynchronous reset and outputs are defined out of reset.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_ret       <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_ex_opcode <= '0;
            r_ex_rd     <= '0;
            r_ex_imm    <= '0;
            r_ex_wen    <= 1'b0;
            r_ex_fwd_a  <= FWD_RF;
            r_ex_fwd_b  <= FWD_RF;
        end else begin
            // The return pulse is an event, not state: it never repeats across
            // stalled cycles because acceptance itself requires !stall.
            r_ret <= w_ret_accept;
            if (!stall) begin
                if (w_bubble) begin
                    r_ex_valid  <= 1'b0;
                    r_ex_opcode <= '0;
                    r_ex_rd     <= '0;
                    r_ex_imm    <= '0;
                    r_ex_wen    <= 1'b0;
                    r_ex_fwd_a  <= FWD_RF;
                    r_ex_fwd_b  <= FWD_RF;
                end else begin
                    r_ex_valid  <= 1'b1;
                    r_ex_opcode <= w_opcode;
                    r_ex_rd     <= w_rd;
                    r_ex_imm    <= w_imm;
                    r_ex_wen    <= w_writes_rd;
                    r_ex_fwd_a  <= w_fwd_a;
                    r_ex_fwd_b  <= w_fwd_b;
                end
            end
        end
    end

    assign ret       = r_ret;
    assign ex_valid  = r_ex_valid;
    assign ex_opcode = r_ex_opcode;
    assign ex_rd     = r_ex_rd;
    assign ex_imm    = r_ex_imm;
    assign ex_wen    = r_ex_wen;
    assign ex_fwd_a  = r_ex_fwd_a;
    assign ex_fwd_b  = r_ex_fwd_b;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Directed self-checking bench for decode_stage (ADDR_W=5, DATA_W=32,
// RET_LAT=3). Inputs change one time unit after the rising edge; registered
// outputs are sampled there and combinational outputs a further unit later.
// Branch expectations follow DECODE_BRANCH_RESOLVE_EN as built.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int RET_LAT = 3;
    localparam int IMM_W   = 24 - 3 * ADDR_W;

    localparam logic [7:0] OP_ALU  = 8'h00;
    localparam logic [7:0] OP_ALUI = 8'h40;
    localparam logic [7:0] OP_LD   = 8'h80;
    localparam logic [7:0] OP_ST   = 8'hA0;
    localparam logic [7:0] OP_BEQ  = 8'hC0;
    localparam logic [7:0] OP_RET  = 8'hE0;

    logic                  clock = 1'b0;
    logic                  nreset;
    logic                  stall;
    logic [31:0]           instruction_word;
    logic                  instr_valid;
    logic [1:0]            reg_file_ren;
    logic [2*ADDR_W-1:0]   reg_file_read_addr;
    logic [DATA_W-1:0]     rs1_data;
    logic [DATA_W-1:0]     rs2_data;
    logic [ADDR_W-1:0]     ex_mem_rd;
    logic [ADDR_W-1:0]     mem_wb_rd;
    logic                  ex_mem_wen;
    logic                  mem_wb_wen;
    logic [DATA_W-1:0]     ex_mem_result;
    logic [DATA_W-1:0]     mem_wb_result;
    logic                  take_branch_address;
    logic [IMM_W-1:0]      branch_offset;
    logic                  request_stall;
    logic                  ret;
    logic                  ex_valid;
    logic [7:0]            ex_opcode;
    logic [ADDR_W-1:0]     ex_rd;
    logic [IMM_W-1:0]      ex_imm;
    logic                  ex_wen;
    logic [1:0]            ex_fwd_a;
    logic [1:0]            ex_fwd_b;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RET_LAT (RET_LAT)
    ) dut (
        .clock               (clock),
        .nreset              (nreset),
        .stall               (stall),
        .instruction_word    (instruction_word),
        .instr_valid         (instr_valid),
        .reg_file_ren        (reg_file_ren),
        .reg_file_read_addr  (reg_file_read_addr),
        .rs1_data            (rs1_data),
        .rs2_data            (rs2_data),
        .ex_mem_rd           (ex_mem_rd),
        .mem_wb_rd           (mem_wb_rd),
        .ex_mem_wen          (ex_mem_wen),
        .mem_wb_wen          (mem_wb_wen),
        .ex_mem_result       (ex_mem_result),
        .mem_wb_result       (mem_wb_result),
        .take_branch_address (take_branch_address),
        .branch_offset       (branch_offset),
        .request_stall       (request_stall),
        .ret                 (ret),
        .ex_valid            (ex_valid),
        .ex_opcode           (ex_opcode),
        .ex_rd               (ex_rd),
        .ex_imm              (ex_imm),
        .ex_wen              (ex_wen),
        .ex_fwd_a            (ex_fwd_a),
        .ex_fwd_b            (ex_fwd_b)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [IMM_W-1:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int ret_hi;

        nreset           = 1'b0;
        stall            = 1'b0;
        instruction_word = enc(OP_ALU, 5'd7, 5'd3, 5'd4, '0);
        instr_valid      = 1'b1;
        rs1_data         = '0;
        rs2_data         = '0;
        ex_mem_rd        = '0;
        mem_wb_rd        = '0;
        ex_mem_wen       = 1'b0;
        mem_wb_wen       = 1'b0;
        ex_mem_result    = '0;
        mem_wb_result    = '0;

        // Reset: registered outputs clear, combinational outputs forced 0.
        #2;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ret", ret, 0);
        check("rst_req_stall", request_stall, 0);
        check("rst_ren", reg_file_ren, 0);
        check("rst_raddr", reg_file_read_addr, 0);
        check("rst_take", take_branch_address, 0);
        tick();
        check("rst_hold_ex_valid", ex_valid, 0);
        #2;
        nreset = 1'b1;

        // ALU reg-reg: rs1 from EX/MEM, rs2 from MEM/WB.
        ex_mem_rd = 5'd3; ex_mem_wen = 1'b1;
        mem_wb_rd = 5'd4; mem_wb_wen = 1'b1;
        #1;
        check("rr_ren", reg_file_ren, 2'b11);
        check("rr_raddr", reg_file_read_addr, {5'd4, 5'd3});
        check("rr_req_stall", request_stall, 0);
        tick();
        check("rr_ex_valid", ex_valid, 1);
        check("rr_fwd_a", ex_fwd_a, 2'b01);
        check("rr_fwd_b", ex_fwd_b, 2'b10);
        check("rr_ex_rd", ex_rd, 7);
        check("rr_ex_wen", ex_wen, 1);

        // ALU imm: both stages hit rs1, EX/MEM wins; rs2 not read.
        instruction_word = enc(OP_ALUI, 5'd9, 5'd4, 5'd0, 9'h1AB);
        ex_mem_rd = 5'd4; mem_wb_rd = 5'd4;
        #1;
        check("imm_ren", reg_file_ren, 2'b01);
        tick();
        check("imm_fwd_a", ex_fwd_a, 2'b01);
        check("imm_fwd_b", ex_fwd_b, 2'b00);
        check("imm_ex_imm", ex_imm, 9'h1AB);
        check("imm_ex_opcode", ex_opcode, OP_ALUI);

        // Register 0 never forwards.
        instruction_word = enc(OP_ALUI, 5'd1, 5'd0, 5'd0, '0);
        ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
        tick();
        check("r0_fwd_a", ex_fwd_a, 2'b00);
        check("r0_ex_valid", ex_valid, 1);
        ex_mem_wen = 1'b0; mem_wb_wen = 1'b0;

        // Load r5, then a consumer of r5: one bubble, then reissue forwarded.
        instruction_word = enc(OP_LD, 5'd5, 5'd2, 5'd0, '0);
        tick();
        check("ld_ex_opcode", ex_opcode, OP_LD);
        check("ld_ex_rd", ex_rd, 5);
        check("ld_ex_wen", ex_wen, 1);
        instruction_word = enc(OP_ALU, 5'd6, 5'd5, 5'd1, '0);
        #1;
        check("lu_req_stall", request_stall, 1);
        stall = 1'b1;
        tick();
        check("lu_req_stall_under_stall", request_stall, 1);
        check("lu_stall_hold_opcode", ex_opcode, OP_LD);
        check("lu_stall_hold_valid", ex_valid, 1);
        stall = 1'b0;
        tick();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_wen", ex_wen, 0);
        ex_mem_rd = 5'd5; ex_mem_wen = 1'b1;
        #1;
        check("lu_release", request_stall, 0);
        tick();
        check("lu_reissue_valid", ex_valid, 1);
        check("lu_reissue_rd", ex_rd, 6);
        check("lu_reissue_fwd_a", ex_fwd_a, 2'b01);
        check("lu_reissue_fwd_b", ex_fwd_b, 2'b00);
        ex_mem_wen = 1'b0;

        // instr_valid low loads a bubble and reads nothing.
        instr_valid = 1'b0;
        #1;
        check("inv_ren", reg_file_ren, 0);
        tick();
        check("inv_ex_valid", ex_valid, 0);
        instr_valid = 1'b1;

        // Store reads both sources and writes nothing.
        instruction_word = enc(OP_ST, 5'd0, 5'd1, 5'd2, '0);
        #1;
        check("st_ren", reg_file_ren, 2'b11);
        tick();
        check("st_ex_valid", ex_valid, 1);
        check("st_ex_wen", ex_wen, 0);

        // Stall wins over a bubble request.
        stall = 1'b1; instr_valid = 1'b0;
        tick();
        check("stall_hold_valid", ex_valid, 1);
        check("stall_hold_opcode", ex_opcode, OP_ST);
        stall = 1'b0; instr_valid = 1'b1;

        // BEQ right behind a producer of its rs2, equal operands.
        instruction_word = enc(OP_ALUI, 5'd2, 5'd3, 5'd0, '0);
        tick();
        instruction_word = enc(OP_BEQ, 5'd0, 5'd1, 5'd2, 9'h05A);
        rs1_data = 32'h1234; rs2_data = 32'h1234;
        #1;
`ifdef DECODE_BRANCH_RESOLVE_EN
        check("beq_dep_stall", request_stall, 1);
        check("beq_dep_take", take_branch_address, 0);
        tick();
        check("beq_dep_bubble", ex_valid, 0);
        #1;
        check("beq_take", take_branch_address, 1);
        check("beq_offset", branch_offset, 9'h05A);
        check("beq_take_no_stall", request_stall, 0);
        tick();
        check("beq_taken_bubble", ex_valid, 0);
`else
        check("beq_off_stall", request_stall, 0);
        check("beq_off_take", take_branch_address, 0);
        check("beq_off_offset", branch_offset, 0);
        tick();
        check("beq_off_ex_valid", ex_valid, 1);
        check("beq_off_ex_opcode", ex_opcode, OP_BEQ);
        check("beq_off_ex_wen", ex_wen, 0);
`endif

        // BEQ with unequal operands is not taken and enters ID/EX.
        rs2_data = 32'h1235;
        #1;
        check("beq_ne_take", take_branch_address, 0);
        tick();
        check("beq_ne_ex_valid", ex_valid, 1);

        // BEQ equal only through the EX/MEM forwarded value.
        rs1_data = 32'h0000_0001; rs2_data = 32'h1234;
        ex_mem_rd = 5'd1; ex_mem_wen = 1'b1; ex_mem_result = 32'h1234;
        #1;
`ifdef DECODE_BRANCH_RESOLVE_EN
        check("beq_fwd_take", take_branch_address, 1);
`else
        check("beq_fwd_take_off", take_branch_address, 0);
`endif
        tick();
        ex_mem_wen = 1'b0;

        // Return: one ret pulse, request_stall for exactly RET_LAT cycles.
        instruction_word = enc(OP_RET, '0, '0, '0, '0);
        #1;
        check("ret_accept_no_stall", request_stall, 0);
        tick();
        check("ret_pulse", ret, 1);
        check("ret_ex_opcode", ex_opcode, OP_RET);
        check("ret_ex_valid", ex_valid, 1);
        instruction_word = enc(OP_ALU, 5'd7, 5'd3, 5'd4, '0);
        #1;
        check("ret_wait_ren", reg_file_ren, 0);
        n = 0; ret_hi = 0;
        while (request_stall === 1'b1 && n < 20) begin
            n++;
            tick();
            if (ret === 1'b1) ret_hi++;
        end
        check("ret_stall_cycles", n, 3);
        check("ret_pulse_once", ret_hi, 0);
        check("ret_wait_bubble", ex_valid, 0);

        // Return with a 2-cycle global stall mid-sequence: 5 stall cycles.
        instruction_word = enc(OP_RET, '0, '0, '0, '0);
        tick();
        check("ret2_pulse", ret, 1);
        instruction_word = enc(OP_ALU, 5'd7, 5'd3, 5'd4, '0);
        n = 0; ret_hi = 0;
        while (request_stall === 1'b1 && n < 20) begin
            n++;
            stall = (n == 2 || n == 3);
            tick();
            if (ret === 1'b1) ret_hi++;
        end
        stall = 1'b0;
        check("ret2_stall_cycles", n, 5);
        check("ret2_pulse_once", ret_hi, 0);

        // Reset during RET_WAIT aborts the sequence.
        instruction_word = enc(OP_RET, '0, '0, '0, '0);
        tick();
        instruction_word = enc(OP_ALU, 5'd7, 5'd3, 5'd4, '0);
        tick();
        check("rw_in_wait", request_stall, 1);
        nreset = 1'b0;
        #1;
        check("rw_rst_ex_valid", ex_valid, 0);
        check("rw_rst_ret", ret, 0);
        check("rw_rst_req_stall", request_stall, 0);
        check("rw_rst_ren", reg_file_ren, 0);
        check("rw_rst_opcode", ex_opcode, 0);
        #1;
        nreset = 1'b1;
        #1;
        check("rw_idle_req_stall", request_stall, 0);
        check("rw_idle_ren", reg_file_ren, 2'b11);
        tick();
        check("rw_idle_ex_valid", ex_valid, 1);
        check("rw_idle_ex_rd", ex_rd, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
